ewb_mem_arbiter: RTL and testbench

EWB_MEM_ARBITER -- requirements
Module: ewb_mem_arbiter

---
 rtl/rv32i_types.sv | 18 +
 rtl/ewb_mem_arbiter.sv | 124 ++++++++++++
 tb/tb_ewb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared types and line-geometry constants for the L2-side memory path.
package rv32i_types;

    localparam int LINE_WIDTH  = 256;
    localparam int OFFSET_BITS = 5;
    localparam int ADDR_WIDTH  = 32;

    // Clears the byte-offset bits so an address points at the start of its line.
    localparam logic [ADDR_WIDTH-1:0] LINE_ADDR_MASK =
        ~((ADDR_WIDTH'(1) << OFFSET_BITS) - ADDR_WIDTH'(1));

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ewb_mem_arbiter.sv
// Arbitrates the single memory port between L2 line fills and eviction write-buffer drains,
// bounding how long fills may starve a non-empty EWB.
module ewb_mem_arbiter
    import rv32i_types::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  l2_read_i,
    input  logic [ADDR_WIDTH-1:0] l2_addr_i,
    output logic [LINE_WIDTH-1:0] l2_rdata_o,
    output logic                  l2_resp_o,

    input  logic                  ewb_empty_i,
    input  logic                  ewb_full_i,
    input  logic [LINE_WIDTH-1:0] ewb_data_i,
    input  logic [ADDR_WIDTH-1:0] ewb_addr_i,
    output logic                  ewb_yumi_o,

    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [LINE_WIDTH-1:0] mem_wdata_o,
    input  logic [LINE_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_resp_i
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_t            state;
    arb_state_t            next_state;
    logic [CNT_W-1:0]      starve_cnt;
    logic [LINE_WIDTH-1:0] wb_data;
    logic [ADDR_WIDTH-1:0] wb_addr;

    logic                  read_grant;
    logic                  write_grant;
    logic                  idle_read;
    logic                  idle_write;

    // Fills win unless the EWB is full or has already waited STARVE_MAX fills.
    always_comb begin
        read_grant  = l2_read_i &
                      (ewb_empty_i | (~ewb_full_i & (starve_cnt < CNT_MAX)));
        write_grant = ~ewb_empty_i &
                      (~l2_read_i | ewb_full_i | (starve_cnt == CNT_MAX));
        idle_read   = (state == IDLE) & read_grant;
        idle_write  = (state == IDLE) & write_grant;
    end

    // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            // NOTE: wb_data/wb_addr are ordinary registers, not a RAM, so they clear with the rest.
            wb_data    <= '0;
            wb_addr    <= '0;
        end else begin
            state <= next_state;

            if (ewb_empty_i || idle_write) begin
                starve_cnt <= '0;
            end else if (idle_read && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            if (idle_write) begin
                wb_data <= ewb_data_i;
                wb_addr <= ewb_addr_i;
            end
        end
    end

    // Every op returns through IDLE so arbitration is re-evaluated per transfer.
    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        next_state  = state;
        l2_rdata_o  = '0;
        l2_resp_o   = 1'b0;
        ewb_yumi_o  = 1'b0;
        mem_read_o  = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;

        if (rst) begin
            unique case (state)
                IDLE: begin
                    if (read_grant) begin
                        next_state = READ;
                    end else if (write_grant) begin
                        next_state = WRITE;
                        ewb_yumi_o = 1'b1;
                    end
                end
                READ: begin
                    mem_read_o = 1'b1;
                    mem_addr_o = l2_addr_i & LINE_ADDR_MASK;
                    if (mem_resp_i) begin
                        l2_resp_o  = 1'b1;
                        l2_rdata_o = mem_rdata_i;
                        next_state = IDLE;
                    end
                end
                WRITE: begin
                    mem_write_o = 1'b1;
                    mem_addr_o  = wb_addr;
                    mem_wdata_o = wb_data;
                    if (mem_resp_i) begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ewb_mem_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter plus directed scenarios.
module tb_ewb_mem_arbiter;
    import rv32i_types::*;

    localparam int SM = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         l2_read_i = 1'b0;
    logic [31:0]  l2_addr_i = '0;
    logic [255:0] l2_rdata_o;
    logic         l2_resp_o;
    logic         ewb_empty_i = 1'b1;
    logic         ewb_full_i = 1'b0;
    logic [255:0] ewb_data_i = '0;
    logic [31:0]  ewb_addr_i = '0;
    logic         ewb_yumi_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic [255:0] mem_rdata_i = '0;
    logic         mem_resp_i = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    bit checking = 1'b0;

    ewb_mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .rst(rst),
        .l2_read_i(l2_read_i), .l2_addr_i(l2_addr_i),
        .l2_rdata_o(l2_rdata_o), .l2_resp_o(l2_resp_o),
        .ewb_empty_i(ewb_empty_i), .ewb_full_i(ewb_full_i),
        .ewb_data_i(ewb_data_i), .ewb_addr_i(ewb_addr_i), .ewb_yumi_o(ewb_yumi_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Model: which transfer is on the memory port, and how many fills the EWB has waited.
    localparam int OP_NONE = 0, OP_FILL = 1, OP_DRAIN = 2;
    int           m_op = OP_NONE;
    int           m_wait = 0;
    logic [31:0]  m_wb_addr = '0;
    logic [255:0] m_wb_data = '0;

    function automatic bit fill_wins();
        return l2_read_i && (ewb_empty_i || (!ewb_full_i && m_wait < SM));
    endfunction

    function automatic bit drain_wins();
        return !ewb_empty_i && (!l2_read_i || ewb_full_i || m_wait == SM);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_op = OP_NONE;
            m_wait = 0;
            m_wb_addr = '0;
            m_wb_data = '0;
        end else begin
            if (m_op == OP_NONE) begin
                if (fill_wins()) begin
                    m_op = OP_FILL;
                    if (!ewb_empty_i && m_wait < SM) m_wait = m_wait + 1;
                end else if (drain_wins()) begin
                    m_op = OP_DRAIN;
                    m_wait = 0;
                    m_wb_addr = ewb_addr_i;
                    m_wb_data = ewb_data_i;
                end
            end else if (mem_resp_i) begin
                m_op = OP_NONE;
            end
            if (ewb_empty_i) m_wait = 0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            logic         e_rd, e_wr, e_resp, e_yumi;
            logic [31:0]  e_addr;
            logic [255:0] e_wdata, e_rdata;
            e_rd = 0; e_wr = 0; e_resp = 0; e_yumi = 0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
            if (rst) begin
                if (m_op == OP_NONE) begin
                    e_yumi = !fill_wins() && drain_wins();
                end else if (m_op == OP_FILL) begin
                    e_rd = 1;
                    e_addr = {l2_addr_i[31:5], 5'b0};
                    e_resp = mem_resp_i;
                    e_rdata = mem_resp_i ? mem_rdata_i : '0;
                end else begin
                    e_wr = 1;
                    e_addr = m_wb_addr;
                    e_wdata = m_wb_data;
                end
            end
            check("mem_read", 256'(mem_read_o), 256'(e_rd));
            check("mem_write", 256'(mem_write_o), 256'(e_wr));
            check("mem_addr", 256'(mem_addr_o), 256'(e_addr));
            check("mem_wdata", mem_wdata_o, e_wdata);
            check("l2_resp", 256'(l2_resp_o), 256'(e_resp));
            check("l2_rdata", l2_rdata_o, e_rdata);
            check("ewb_yumi", 256'(ewb_yumi_o), 256'(e_yumi));
            check("starve_cnt", 256'(dut.starve_cnt), 256'(m_wait));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        l2_read_i = 0; ewb_empty_i = 1; ewb_full_i = 0; mem_resp_i = 0;
    endtask

    initial begin
        string seq;
        logic [255:0] pat;
        logic [31:0]  cnt_at_w;

        tick();
        checking = 1'b1;
        tick();
        rst = 1'b1;

        // Fill only: line-aligned address one cycle after the request, data passed through.
        l2_read_i = 1; l2_addr_i = 32'h1234_5678;
        tick();
        check("rd_mem_read", 256'(mem_read_o), 256'(1));
        check("rd_mem_addr", 256'(mem_addr_o), 256'(32'h1234_5660));
        pat = {32{8'hA5}};
        mem_rdata_i = pat; mem_resp_i = 1;
        #1;
        check("rd_l2_resp", 256'(l2_resp_o), 256'(1));
        check("rd_l2_rdata", l2_rdata_o, pat);
        tick();
        quiet();
        #1;
        check("rd_back_idle", 256'(mem_read_o), 256'(0));

        // Drain only: yumi in the grant cycle, then a held write to the head address.
        ewb_empty_i = 0; ewb_addr_i = 32'h8000_0040; pat = rand256(); ewb_data_i = pat;
        #1;
        check("wr_yumi", 256'(ewb_yumi_o), 256'(1));
        tick();
        ewb_empty_i = 1; ewb_data_i = '0; ewb_addr_i = '0;
        #1;
        check("wr_mem_write", 256'(mem_write_o), 256'(1));
        check("wr_mem_addr", 256'(mem_addr_o), 256'(32'h8000_0040));
        check("wr_mem_wdata", mem_wdata_o, pat);
        check("wr_no_yumi", 256'(ewb_yumi_o), 256'(0));
        tick(); tick();
        check("wr_held", 256'(mem_write_o), 256'(1));
        mem_resp_i = 1;
        tick();
        mem_resp_i = 0;
        #1;
        check("wr_back_idle", 256'(mem_write_o), 256'(0));

        // Starvation: four fills, then the waiting EWB drains and its wait count clears.
        seq = ""; cnt_at_w = 32'hFFFF_FFFF;
        ewb_empty_i = 0; ewb_full_i = 0; l2_read_i = 1; l2_addr_i = 32'h0000_1000;
        ewb_addr_i = 32'h4000_0000; mem_resp_i = 1;
        for (int i = 0; i < 40 && seq.len() < 5; i++) begin
            tick();
            if (mem_read_o) seq = {seq, "R"};
            if (mem_write_o) begin
                seq = {seq, "W"};
                cnt_at_w = 32'(dut.starve_cnt);
            end
        end
        check("starve_seq", 256'(seq == "RRRRW"), 256'(1));
        check("starve_cleared", 256'(cnt_at_w), 256'(0));
        tick();
        quiet();
        tick();

        // Full EWB beats a pending fill; the fill follows once the head is dequeued.
        seq = "";
        ewb_empty_i = 0; ewb_full_i = 1; l2_read_i = 1; mem_resp_i = 1;
        for (int i = 0; i < 20 && seq.len() < 2; i++) begin
            tick();
            if (mem_read_o) seq = {seq, "R"};
            if (mem_write_o) begin
                seq = {seq, "W"};
                ewb_empty_i = 1; ewb_full_i = 0;
            end
        end
        check("full_prio_seq", 256'(seq == "WR"), 256'(1));
        tick();
        quiet();
        tick();

        // Reset during a write aborts it without any handshake.
        ewb_empty_i = 0; ewb_addr_i = 32'h9000_0080;
        tick();
        check("rst_pre_write", 256'(mem_write_o), 256'(1));
        rst = 0;
        #1;
        check("rst_outputs_low", 256'({mem_write_o, mem_read_o, ewb_yumi_o, l2_resp_o}), 256'(0));
        tick();
        rst = 1; ewb_empty_i = 1;
        #1;
        check("rst_idle_outputs", 256'({mem_write_o, mem_read_o, ewb_yumi_o, l2_resp_o}), 256'(0));
        check("rst_idle_state", 256'(dut.state == IDLE), 256'(1));

        // Spurious response in IDLE is ignored.
        mem_resp_i = 1; mem_rdata_i = rand256();
        #1;
        check("spur_no_resp", 256'(l2_resp_o), 256'(0));
        check("spur_no_rdata", l2_rdata_o, 256'(0));
        tick();
        check("spur_still_idle", 256'(dut.state == IDLE), 256'(1));
        mem_resp_i = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            rst = ($urandom_range(0, 99) != 0);
            l2_read_i = ($urandom_range(0, 2) != 0);
            if (!l2_read_i) l2_addr_i = $urandom;
            ewb_empty_i = ($urandom_range(0, 2) == 0);
            ewb_full_i = !ewb_empty_i && ($urandom_range(0, 3) == 0);
            ewb_addr_i = $urandom;
            ewb_data_i = rand256();
            mem_rdata_i = rand256();
            mem_resp_i = ($urandom_range(0, 2) == 0);
        end
        tick();
        checking = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
